// File: rtl/uart_mem_loader_if.sv
// Memory write-port bundle between uart_mem_loader and the IRAM.
interface uart_mem_loader_if #(
    parameter int ADDR_W = 16
);
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_data;

    modport master (output mem_we, output mem_addr, output mem_data);
    modport slave  (input  mem_we, input  mem_addr, input  mem_data);
endinterface

// File: rtl/uart_mem_loader.sv
// UART boot loader: 8N1 receiver, 16-bit length header, payload written to consecutive addresses.
// Define UART_LOADER_CHECKSUM_EN to expect a trailing modulo-256 checksum byte after the payload.
module uart_mem_loader #(
    parameter int                CLKS_PER_BIT = 434,
    parameter int                ADDR_W       = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR    = {ADDR_W{1'b0}}
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               rx,
    input  logic               start,
    uart_mem_loader_if.master  mem,
    output logic               busy,
    output logic               done,
    output logic               frame_err,
    output logic [15:0]        byte_count,
    output logic               chk_err
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
    typedef enum logic [2:0] {
        L_IDLE, L_LEN_HI, L_LEN_LO, L_LOAD,
`ifdef UART_LOADER_CHECKSUM_EN
        L_CHK,
`endif
        L_DONE, L_ERR
    } ld_state_e;

`ifdef UART_LOADER_CHECKSUM_EN
    localparam ld_state_e PAYLOAD_END = L_CHK;
    logic [7:0] sum_q, sum_d;
    logic       chk_err_q, chk_err_d;
`else
    localparam ld_state_e PAYLOAD_END = L_DONE;
`endif

    logic              rx_meta_q, rx_sync_q, rx_prev_q;
    rx_state_e         rx_state_q, rx_state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [7:0]        shift_q, shift_d;
    logic              rx_byte_valid_s, rx_frame_err_s, start_acc_s;

    ld_state_e         ld_state_q, ld_state_d;
    logic [7:0]        len_hi_q, len_hi_d;
    logic [15:0]       remain_q, remain_d;
    logic [ADDR_W-1:0] addr_q, addr_d, mem_addr_q, mem_addr_d;
    logic [7:0]        mem_data_q, mem_data_d;
    logic              mem_we_q, mem_we_d;
    logic [15:0]       count_q, count_d;
    logic              busy_q, busy_d, done_q, done_d, ferr_q, ferr_d;

    assign start_acc_s = start && (ld_state_q inside {L_IDLE, L_DONE, L_ERR});

    // rx synchronizer plus one extra stage for falling-edge detection
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    // Receiver next state; valid/error pulses fire in the stop-bit sample cycle
    always_comb begin
        rx_state_d      = rx_state_q;
        cnt_d           = cnt_q;
        bit_idx_d       = bit_idx_q;
        shift_d         = shift_q;
        rx_byte_valid_s = 1'b0;
        rx_frame_err_s  = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (rx_prev_q && !rx_sync_q) begin
                    rx_state_d = RX_START;
                    cnt_d      = {CW{1'b0}};
                end else begin
                    rx_state_d = RX_IDLE;
                end
            end
            RX_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d     = {CW{1'b0}};
                    bit_idx_d = 3'd0;
                    if (!rx_sync_q) begin
                        rx_state_d = RX_DATA;
                    end else begin
                        rx_state_d = RX_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                end
            end
            RX_DATA: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d     = {CW{1'b0}};
                    shift_d   = {rx_sync_q, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end else begin
                        rx_state_d = RX_DATA;
                    end
                end else begin
                    cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                end
            end
            RX_STOP: begin
                if (cnt_q == CNT_FULL) begin
                    rx_state_d      = RX_IDLE;
                    rx_byte_valid_s = rx_sync_q;
                    rx_frame_err_s  = !rx_sync_q;
                end else begin
                    cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
        if (start_acc_s) begin
            rx_state_d = RX_IDLE;
        end else begin
            rx_state_d = rx_state_d;
        end
    end

    // Receiver state register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rx_state_q <= RX_IDLE;
            cnt_q      <= {CW{1'b0}};
            bit_idx_q  <= 3'd0;
            shift_q    <= 8'h00;
        end else begin
            rx_state_q <= rx_state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
        end
    end

    // Loader next state; flags are derived from the next state so they land with the final write
    always_comb begin
        ld_state_d = ld_state_q;
        len_hi_d   = len_hi_q;
        remain_d   = remain_q;
        addr_d     = addr_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        mem_we_d   = 1'b0;
        count_d    = count_q;
        ferr_d     = ferr_q;
`ifdef UART_LOADER_CHECKSUM_EN
        sum_d      = sum_q;
        chk_err_d  = chk_err_q;
`endif
        if (start_acc_s) begin
            ld_state_d = L_LEN_HI;
            addr_d     = BASE_ADDR;
            count_d    = 16'd0;
            ferr_d     = 1'b0;
`ifdef UART_LOADER_CHECKSUM_EN
            sum_d      = 8'h00;
            chk_err_d  = 1'b0;
`endif
        end else if (rx_frame_err_s && !(ld_state_q inside {L_IDLE, L_DONE, L_ERR})) begin
            ld_state_d = L_ERR;
            ferr_d     = 1'b1;
        end else if (rx_byte_valid_s) begin
            case (ld_state_q)
                L_LEN_HI: begin
                    len_hi_d   = shift_q;
                    ld_state_d = L_LEN_LO;
                end
                L_LEN_LO: begin
                    remain_d = {len_hi_q, shift_q};
                    if ({len_hi_q, shift_q} == 16'd0) begin
                        ld_state_d = PAYLOAD_END;
                    end else begin
                        ld_state_d = L_LOAD;
                    end
                end
                L_LOAD: begin
                    mem_we_d   = 1'b1;
                    mem_addr_d = addr_q;
                    mem_data_d = shift_q;
                    addr_d     = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                    count_d    = count_q + 16'd1;
                    remain_d   = remain_q - 16'd1;
`ifdef UART_LOADER_CHECKSUM_EN
                    sum_d      = sum_q + shift_q;
`endif
                    if (remain_q == 16'd1) begin
                        ld_state_d = PAYLOAD_END;
                    end else begin
                        ld_state_d = L_LOAD;
                    end
                end
`ifdef UART_LOADER_CHECKSUM_EN
                L_CHK: begin
                    if (shift_q == sum_q) begin
                        ld_state_d = L_DONE;
                    end else begin
                        ld_state_d = L_ERR;
                        chk_err_d  = 1'b1;
                    end
                end
`endif
                default: ld_state_d = ld_state_q;
            endcase
        end else begin
            ld_state_d = ld_state_q;
        end
        busy_d = !(ld_state_d inside {L_IDLE, L_DONE, L_ERR});
        done_d = (ld_state_d == L_DONE);
    end

    // Loader state and registered outputs
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ld_state_q <= L_IDLE;
            len_hi_q   <= 8'h00;
            remain_q   <= 16'd0;
            addr_q     <= BASE_ADDR;
            mem_addr_q <= BASE_ADDR;
            mem_data_q <= 8'h00;
            mem_we_q   <= 1'b0;
            count_q    <= 16'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ferr_q     <= 1'b0;
`ifdef UART_LOADER_CHECKSUM_EN
            sum_q      <= 8'h00;
            chk_err_q  <= 1'b0;
`endif
        end else begin
            ld_state_q <= ld_state_d;
            len_hi_q   <= len_hi_d;
            remain_q   <= remain_d;
            addr_q     <= addr_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            mem_we_q   <= mem_we_d;
            count_q    <= count_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ferr_q     <= ferr_d;
`ifdef UART_LOADER_CHECKSUM_EN
            sum_q      <= sum_d;
            chk_err_q  <= chk_err_d;
`endif
        end
    end

    assign mem.mem_we   = mem_we_q;
    assign mem.mem_addr = mem_addr_q;
    assign mem.mem_data = mem_data_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign frame_err    = ferr_q;
    assign byte_count   = count_q;
`ifdef UART_LOADER_CHECKSUM_EN
    assign chk_err      = chk_err_q;
`else
    assign chk_err      = 1'b0;
`endif
endmodule

// File: tb/tb_uart_mem_loader.sv
// Self-checking bench: two loader instances (16-bit base 0, 4-bit base 14) share one UART line.
module tb_uart_mem_loader;
    localparam int CLKS = 16;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic rx = 1'b1;
    logic start = 1'b0;
    logic busy_a, done_a, ferr_a, chk_a, busy_b, done_b, ferr_b, chk_b;
    logic [15:0] cnt_a, cnt_b;

    int errors = 0;
    int checks = 0;
    logic [7:0] payload [0:15];
    logic [23:0] log_a [$];
    logic [11:0] log_b [$];

    uart_mem_loader_if #(.ADDR_W(16)) mem_a ();
    uart_mem_loader_if #(.ADDR_W(4))  mem_b ();

    uart_mem_loader #(.CLKS_PER_BIT(CLKS), .ADDR_W(16), .BASE_ADDR(16'd0)) dut_a (
        .clk(clk), .reset_n(reset_n), .rx(rx), .start(start), .mem(mem_a),
        .busy(busy_a), .done(done_a), .frame_err(ferr_a), .byte_count(cnt_a), .chk_err(chk_a));

    uart_mem_loader #(.CLKS_PER_BIT(CLKS), .ADDR_W(4), .BASE_ADDR(4'd14)) dut_b (
        .clk(clk), .reset_n(reset_n), .rx(rx), .start(start), .mem(mem_b),
        .busy(busy_b), .done(done_b), .frame_err(ferr_b), .byte_count(cnt_b), .chk_err(chk_b));

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_a.mem_we) log_a.push_back({mem_a.mem_addr, mem_a.mem_data});
        if (mem_b.mem_we) log_b.push_back({mem_b.mem_addr, mem_b.mem_data});
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_bit();
        repeat (CLKS) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_ok);
        rx = 1'b0;
        wait_bit();
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_bit();
        end
        rx = stop_ok;
        wait_bit();
        rx = 1'b1;
        wait_bit();
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " mem_we"}, 32'(mem_a.mem_we), 32'd0);
        check({tag, " mem_addr"}, 32'(mem_a.mem_addr), 32'd0);
        check({tag, " mem_data"}, 32'(mem_a.mem_data), 32'd0);
        check({tag, " busy"}, 32'(busy_a), 32'd0);
        check({tag, " done"}, 32'(done_a), 32'd0);
        check({tag, " frame_err"}, 32'(ferr_a), 32'd0);
        check({tag, " byte_count"}, 32'(cnt_a), 32'd0);
        check({tag, " chk_err"}, 32'(chk_a), 32'd0);
        check({tag, " b mem_addr"}, 32'(mem_b.mem_addr), 32'd14);
    endtask

    task automatic check_writes(input string tag, input int n);
        check({tag, " writes a"}, 32'(log_a.size()), 32'(n));
        check({tag, " writes b"}, 32'(log_b.size()), 32'(n));
        for (int i = 0; i < n && i < log_a.size() && i < log_b.size(); i++) begin
            check({tag, " wr a"}, 32'(log_a[i]), 32'({16'(i), payload[i]}));
            check({tag, " wr b"}, 32'(log_b[i]), 32'({4'((14 + i) % 16), payload[i]}));
        end
    endtask

    // Sends one load (header, payload, optional checksum) and compares against the model outcome.
    // bad = frame byte index whose stop bit is forced low (-1 for none).
    task automatic run_frame(input string tag, input int len, input int bad, input logic [7:0] chk_xor);
        int total, sum, nwr;
        logic [7:0] b;
        bit ferr, chkfail, exp_done;
        log_a.delete();
        log_b.delete();
        pulse_start();
        check({tag, " busy after start"}, 32'(busy_a), 32'd1);
        check({tag, " flags cleared"}, 32'({done_a, ferr_a, chk_a}), 32'd0);
        sum = 0;
        for (int i = 0; i < len; i++) sum += payload[i];
        sum = sum % 256;
`ifdef UART_LOADER_CHECKSUM_EN
        total = len + 3;
`else
        total = len + 2;
`endif
        for (int k = 0; k < total; k++) begin
            if (k == 0) b = 8'(len >> 8);
            else if (k == 1) b = 8'(len);
            else if (k < len + 2) b = payload[k - 2];
            else b = 8'(sum) ^ chk_xor;
            send_byte(b, k != bad);
            if (k == bad) break;
        end
        ferr = (bad >= 0) && (bad < total);
        if (!ferr) nwr = len;
        else if (bad < 2) nwr = 0;
        else nwr = (bad - 2 < len) ? bad - 2 : len;
`ifdef UART_LOADER_CHECKSUM_EN
        chkfail = !ferr && (chk_xor != 8'h00);
`else
        chkfail = 1'b0;
`endif
        exp_done = !ferr && !chkfail;
        check_writes(tag, nwr);
        check({tag, " done"}, 32'(done_a), 32'(exp_done));
        check({tag, " frame_err"}, 32'(ferr_a), 32'(ferr));
        check({tag, " chk_err"}, 32'(chk_a), 32'(chkfail));
        check({tag, " busy"}, 32'(busy_a), 32'd0);
        check({tag, " byte_count"}, 32'(cnt_a), 32'(nwr));
        check({tag, " b status"}, 32'({done_b, ferr_b, busy_b, cnt_b}), 32'({exp_done, ferr, 1'b0, 16'(nwr)}));
    endtask

    typedef struct {
        int         len;
        int         bad;
        logic [7:0] d0, d1, d2, d3;
        int         exp_wr;
        logic       exp_done;
        logic       exp_ferr;
    } vec_t;

    vec_t tbl [5];

    initial begin
        tbl[0] = '{3, -1, 8'hA5, 8'h3C, 8'hFF, 8'h00, 3, 1'b1, 1'b0};
        tbl[1] = '{0, -1, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1'b1, 1'b0};
        tbl[2] = '{4,  3, 8'h11, 8'h22, 8'h33, 8'h44, 1, 1'b0, 1'b1};
        tbl[3] = '{2,  1, 8'h66, 8'h77, 8'h00, 8'h00, 0, 1'b0, 1'b1};
        tbl[4] = '{1, -1, 8'h5A, 8'h00, 8'h00, 8'h00, 1, 1'b1, 1'b0};

        repeat (5) @(posedge clk);
        #1;
        check_reset_vals("reset");
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        for (int v = 0; v < 5; v++) begin
            payload[0] = tbl[v].d0;
            payload[1] = tbl[v].d1;
            payload[2] = tbl[v].d2;
            payload[3] = tbl[v].d3;
            run_frame($sformatf("vec%0d", v), tbl[v].len, tbl[v].bad, 8'h00);
            check($sformatf("vec%0d tbl writes", v), 32'(log_a.size()), 32'(tbl[v].exp_wr));
            check($sformatf("vec%0d tbl done", v), 32'(done_a), 32'(tbl[v].exp_done));
            check($sformatf("vec%0d tbl frame_err", v), 32'(ferr_a), 32'(tbl[v].exp_ferr));
        end

        // Short glitch in LEN_HI is rejected; a start pulse mid-load is ignored
        log_a.delete();
        log_b.delete();
        pulse_start();
        rx = 1'b0;
        repeat (CLKS / 2 - 3) @(posedge clk);
        #1 rx = 1'b1;
        repeat (3 * CLKS) @(posedge clk);
        #1;
        check("glitch busy", 32'(busy_a), 32'd1);
        check("glitch byte_count", 32'(cnt_a), 32'd0);
        check("glitch writes", 32'(log_a.size()), 32'd0);
        payload[0] = 8'h77;
        payload[1] = 8'h88;
        send_byte(8'h00, 1'b1);
        send_byte(8'h02, 1'b1);
        send_byte(payload[0], 1'b1);
        pulse_start();
        check("ignored start busy", 32'(busy_a), 32'd1);
        check("ignored start count", 32'(cnt_a), 32'd1);
        send_byte(payload[1], 1'b1);
        check_writes("glitch", 2);
        check("glitch done", 32'(done_a), 32'd1);

        // Random loads against the reference model
        for (int r = 0; r < 8; r++) begin
            int len, bad;
            len = int'($urandom_range(0, 6));
            for (int i = 0; i < len; i++) payload[i] = 8'($urandom);
            bad = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, len + 1)) : -1;
            run_frame($sformatf("rnd%0d", r), len, bad, ($urandom_range(0, 1) == 1) ? 8'h01 : 8'h00);
        end

`ifdef UART_LOADER_CHECKSUM_EN
        payload[0] = 8'h10;
        payload[1] = 8'h20;
        run_frame("chk bad", 2, -1, 8'h01);
        check("chk bad chk_err", 32'(chk_a), 32'd1);
        run_frame("chk good", 2, -1, 8'h00);
        check("chk good done", 32'(done_a), 32'd1);
`endif

        // Reset asserted during the second payload byte
        log_a.delete();
        log_b.delete();
        payload[0] = 8'h01;
        pulse_start();
        send_byte(8'h00, 1'b1);
        send_byte(8'h04, 1'b1);
        send_byte(payload[0], 1'b1);
        fork
            send_byte(8'h02, 1'b1);
            begin
                repeat (4 * CLKS) @(posedge clk);
                #1 reset_n = 1'b0;
                @(posedge clk);
                #1;
                check_reset_vals("midreset");
                repeat (3) @(posedge clk);
                #1 reset_n = 1'b1;
            end
        join
        repeat (3 * CLKS) @(posedge clk);
        #1;
        check("midreset writes", 32'(log_a.size()), 32'd1);
        check("midreset busy", 32'(busy_a), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
